// File: rtl/artec_dma_pkg.sv
// Shared types for the DMA read path: channel settings, dispatch commands and
// the dispatcher state encoding.
package artec_dma_pkg;

  localparam int DMA_CH_NUM = 5;
  localparam int DMA_FB_NUM = 8;
  localparam int DMA_CH_W   = $clog2(DMA_CH_NUM);
  localparam int DMA_FN_W   = $clog2(DMA_FB_NUM);

  typedef struct packed {
    logic [DMA_CH_NUM-1:0] enable;
  } settings_t;

  typedef struct packed {
    logic [DMA_CH_W-1:0] ch;
    logic [DMA_FN_W-1:0] fnum;
  } sync_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE
  } dispatch_state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [DMA_CH_W-1:0] lowest_ch(input logic [DMA_CH_NUM-1:0] m);
    lowest_ch = '0;
    for (int i = DMA_CH_NUM - 1; i >= 0; i--)
      if (m[i]) lowest_ch = DMA_CH_W'(i);
  endfunction

endpackage

// File: rtl/artec_vr_if.sv
// Generic valid/ready channel carrying a W-bit payload.
interface artec_vr_if #(parameter int W = 8);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/artec_fnum_fifo.sv
// Small synchronous FIFO; pointers carry a wrap bit so full/empty fall out of
// a pointer compare. Push while full and pop while empty are ignored.
module artec_fnum_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, rp_q;
  logic             do_push, do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout_o  = mem_q[rp_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/artec_sync_dispatch.sv
// Queues synchronized frame numbers, issues one read command per enabled
// channel for each frame, waits for completions, then frees the buffer slot.
module artec_sync_dispatch
  import artec_dma_pkg::*;
#(
  parameter int CH_NUM = DMA_CH_NUM,
  parameter int FB_NUM = DMA_FB_NUM,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  settings_t         settings_i,
  artec_vr_if.slave         sync_i,
  artec_vr_if.master        cmd_o,
  input  logic [CH_NUM-1:0] done_i,
  output logic [FB_NUM-1:0] fb_free_o,
  output logic              drop_o,
  output logic              busy_o
);

  localparam int FN_W = $clog2(FB_NUM);
  localparam int CH_W = $clog2(CH_NUM);

  dispatch_state_t   state_q, state_d;
  logic [FN_W-1:0]   cur_fnum_q, cur_fnum_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_NUM-1:0] en_q, en_d;
  logic [FB_NUM-1:0] pend_q, pend_d;
  logic              rdy_q;

  logic              full, empty, push, pop;
  logic [FN_W-1:0]   fifo_dout;
  logic              accept, dup, rel;
  logic [CH_NUM-1:0] upper;
  sync_cmd_t         cmd;

  artec_fnum_fifo #(.WIDTH(FN_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .din_i   (sync_i.data),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .dout_o  (fifo_dout)
  );

  // rdy_q keeps ready low during reset even though the empty FIFO is not full.
  assign sync_i.ready = rdy_q && !full;
  assign accept       = sync_i.valid && sync_i.ready;
  assign rel          = (state_q == ST_RELEASE);

  // A slot being released this cycle is free again, so it is not a duplicate.
  always_comb begin
    dup    = pend_q[sync_i.data] && !(rel && (cur_fnum_q == sync_i.data));
    push   = accept && !dup;
    drop_o = accept && dup;
    pend_d = pend_q;
    if (rel)  pend_d[cur_fnum_q]  = 1'b0;
    if (push) pend_d[sync_i.data] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cur_fnum_d = cur_fnum_q;
    ch_d       = ch_q;
    en_d       = en_q;
    pop        = 1'b0;
    upper      = '0;
    for (int i = 0; i < CH_NUM; i++)
      upper[i] = en_q[i] && (i > int'(ch_q));
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cur_fnum_d = fifo_dout;
          en_d       = settings_i.enable;
          ch_d       = lowest_ch(settings_i.enable);
          state_d    = (settings_i.enable == '0) ? ST_RELEASE : ST_ISSUE;
        end
      end
      ST_ISSUE: if (cmd_o.ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_i[ch_q]) begin
          if (upper != '0) begin
            ch_d    = lowest_ch(upper);
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cur_fnum_q <= '0;
      ch_q       <= '0;
      en_q       <= '0;
      pend_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_fnum_q <= cur_fnum_d;
      ch_q       <= ch_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
      rdy_q      <= 1'b1;
    end
  end

  always_comb begin
    cmd.ch   = ch_q;
    cmd.fnum = cur_fnum_q;
  end

  assign cmd_o.valid = (state_q == ST_ISSUE);
  assign cmd_o.data  = cmd;
  assign fb_free_o   = rel ? (FB_NUM'(1) << cur_fnum_q) : '0;
  assign busy_o      = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_artec_sync_dispatch.sv
// Scenario bench for artec_sync_dispatch: directed cases plus randomized
// traffic scored against a frame-level queue model.
module tb_artec_sync_dispatch;
  import artec_dma_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  settings_t  settings;
  logic [4:0] done;
  logic [7:0] fb_free;
  logic       drop, busy;
  int         chk = 0, pass = 0;

  artec_vr_if #(.W(3)) sync_if ();
  artec_vr_if #(.W(6)) cmd_if ();

  artec_sync_dispatch #(.CH_NUM(5), .FB_NUM(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .settings_i (settings),
    .sync_i     (sync_if),
    .cmd_o      (cmd_if),
    .done_i     (done),
    .fb_free_o  (fb_free),
    .drop_o     (drop),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] cw(input int ch, input int f);
    sync_cmd_t c;
    c.ch   = 3'(ch);
    c.fnum = 3'(f);
    return c;
  endfunction

  task automatic test_reset;
    rstn = 1'b0; sync_if.valid = 0; sync_if.data = 0; cmd_if.ready = 0; done = 0;
    settings.enable = 5'h1F;
    repeat (2) @(negedge clk);
    chk++; if (sync_if.ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", sync_if.ready); else pass++;
    chk++; if (cmd_if.valid !== 1'b0) $display("FAIL rst_cmd_valid got %b exp 0", cmd_if.valid); else pass++;
    chk++; if (cmd_if.data !== 6'd0) $display("FAIL rst_cmd_data got %h exp 0", cmd_if.data); else pass++;
    chk++; if (fb_free !== 8'd0) $display("FAIL rst_fb_free got %h exp 0", fb_free); else pass++;
    chk++; if (drop !== 1'b0) $display("FAIL rst_drop got %b exp 0", drop); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass++;
    tick; rstn = 1'b1;
    tick; @(negedge clk);
    chk++; if (sync_if.ready !== 1'b1) $display("FAIL post_rst_ready got %b exp 1", sync_if.ready); else pass++;
    tick;
  endtask

  task automatic test_basic;
    settings.enable = 5'h1F; cmd_if.ready = 1;
    sync_if.valid = 1; sync_if.data = 3;
    @(negedge clk);
    chk++; if (drop !== 1'b0) $display("FAIL basic_drop got %b exp 0", drop); else pass++;
    tick; sync_if.valid = 0;
    @(negedge clk);
    chk++; if (cmd_if.valid !== 1'b0) $display("FAIL basic_pop_cycle_valid got %b exp 0", cmd_if.valid); else pass++;
    chk++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else pass++;
    tick;
    for (int ch = 0; ch < 5; ch++) begin
      @(negedge clk);
      chk++; if ({cmd_if.valid, cmd_if.data} !== {1'b1, cw(ch, 3)})
        $display("FAIL basic_cmd%0d got %b/%h exp 1/%h", ch, cmd_if.valid, cmd_if.data, cw(ch, 3)); else pass++;
      tick; done = 5'(1 << ch);
      @(negedge clk);
      chk++; if ({cmd_if.valid, fb_free} !== 9'd0)
        $display("FAIL basic_wait%0d got valid %b free %h exp 0/0", ch, cmd_if.valid, fb_free); else pass++;
      tick; done = 0;
    end
    @(negedge clk);
    chk++; if (fb_free !== 8'h08) $display("FAIL basic_free got %h exp 08", fb_free); else pass++;
    tick; @(negedge clk);
    chk++; if ({fb_free, busy} !== 9'd0) $display("FAIL basic_after got %h/%b exp 00/0", fb_free, busy); else pass++;
    cmd_if.ready = 0;
    tick;
  endtask

  task automatic test_sparse;
    settings.enable = 5'b10100; cmd_if.ready = 0;
    sync_if.valid = 1; sync_if.data = 7;
    tick; sync_if.valid = 0;
    tick; @(negedge clk);
    chk++; if ({cmd_if.valid, cmd_if.data} !== {1'b1, cw(2, 7)})
      $display("FAIL sparse_cmd2 got %b/%h exp 1/%h", cmd_if.valid, cmd_if.data, cw(2, 7)); else pass++;
    cmd_if.ready = 1;
    tick; cmd_if.ready = 0; settings.enable = 5'h1F;
    @(negedge clk);
    chk++; if (cmd_if.valid !== 1'b0) $display("FAIL sparse_wait got %b exp 0", cmd_if.valid); else pass++;
    tick; tick; done = 5'b00100;
    tick; done = 0;
    @(negedge clk);
    chk++; if ({cmd_if.valid, cmd_if.data} !== {1'b1, cw(4, 7)})
      $display("FAIL sparse_cmd4 got %b/%h exp 1/%h", cmd_if.valid, cmd_if.data, cw(4, 7)); else pass++;
    cmd_if.ready = 1;
    tick; cmd_if.ready = 0; done = 5'b10000;
    tick; done = 0;
    @(negedge clk);
    chk++; if ({cmd_if.valid, fb_free} !== {1'b0, 8'h80})
      $display("FAIL sparse_free got %b/%h exp 0/80", cmd_if.valid, fb_free); else pass++;
    tick;
  endtask

  task automatic test_duplicate;
    int extra = 0;
    settings.enable = 5'b00001; cmd_if.ready = 0;
    sync_if.valid = 1; sync_if.data = 2;
    @(negedge clk);
    chk++; if (drop !== 1'b0) $display("FAIL dup_first_drop got %b exp 0", drop); else pass++;
    tick; @(negedge clk);
    chk++; if (drop !== 1'b1) $display("FAIL dup_second_drop got %b exp 1", drop); else pass++;
    tick; sync_if.valid = 0;
    @(negedge clk);
    chk++; if ({cmd_if.valid, cmd_if.data} !== {1'b1, cw(0, 2)})
      $display("FAIL dup_cmd got %b/%h exp 1/%h", cmd_if.valid, cmd_if.data, cw(0, 2)); else pass++;
    cmd_if.ready = 1;
    tick; cmd_if.ready = 0; done = 1;
    tick; done = 0;
    @(negedge clk);
    chk++; if (fb_free !== 8'h04) $display("FAIL dup_free got %h exp 04", fb_free); else pass++;
    for (int i = 0; i < 8; i++) begin
      tick; @(negedge clk);
      if (cmd_if.valid || fb_free != 0) extra++;
    end
    chk++; if (extra !== 0) $display("FAIL dup_extra_activity got %0d exp 0", extra); else pass++;
    tick;
  endtask

  task automatic test_full;
    bit found;
    settings.enable = 5'b00001; cmd_if.ready = 0;
    for (int k = 0; k < 5; k++) begin
      sync_if.valid = 1; sync_if.data = 3'(k);
      @(negedge clk);
      chk++; if (sync_if.ready !== 1'b1) $display("FAIL full_ready%0d got %b exp 1", k, sync_if.ready); else pass++;
      tick;
    end
    sync_if.valid = 0;
    @(negedge clk);
    chk++; if (sync_if.ready !== 1'b0) $display("FAIL full_ready_low got %b exp 0", sync_if.ready); else pass++;
    for (int k = 0; k < 5; k++) begin
      found = 0;
      for (int t = 0; t < 12 && !found; t++) begin
        @(negedge clk);
        if (cmd_if.valid) found = 1;
      end
      chk++; if (!found || cmd_if.data !== cw(0, k))
        $display("FAIL full_cmd%0d got %b/%h exp 1/%h", k, found, cmd_if.data, cw(0, k)); else pass++;
      cmd_if.ready = 1;
      tick; cmd_if.ready = 0; done = 1;
      tick; done = 0;
      @(negedge clk);
      chk++; if (fb_free !== 8'(1 << k)) $display("FAIL full_free%0d got %h exp %h", k, fb_free, 8'(1 << k)); else pass++;
      tick;
      if (k == 0) begin
        @(negedge clk);
        chk++; if (sync_if.ready !== 1'b0) $display("FAIL full_pop_cycle_ready got %b exp 0", sync_if.ready); else pass++;
        tick; @(negedge clk);
        chk++; if (sync_if.ready !== 1'b1) $display("FAIL full_ready_rise got %b exp 1", sync_if.ready); else pass++;
      end
    end
    tick;
  endtask

  task automatic test_backpressure;
    settings.enable = 5'b00011; cmd_if.ready = 0;
    sync_if.valid = 1; sync_if.data = 5;
    tick; sync_if.valid = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk++; if ({cmd_if.valid, cmd_if.data} !== {1'b1, cw(0, 5)})
        $display("FAIL bp_hold%0d got %b/%h exp 1/%h", i, cmd_if.valid, cmd_if.data, cw(0, 5)); else pass++;
      tick;
    end
    cmd_if.ready = 1; done = 5'b00001;
    tick; cmd_if.ready = 0; done = 5'b00010;
    @(negedge clk);
    chk++; if (cmd_if.valid !== 1'b0) $display("FAIL bp_stray_a got %b exp 0", cmd_if.valid); else pass++;
    tick; done = 0;
    @(negedge clk);
    chk++; if (cmd_if.valid !== 1'b0) $display("FAIL bp_stray_b got %b exp 0", cmd_if.valid); else pass++;
    tick; @(negedge clk);
    chk++; if ({cmd_if.valid, fb_free, busy} !== {1'b0, 8'h00, 1'b1})
      $display("FAIL bp_still_wait got %b/%h/%b exp 0/00/1", cmd_if.valid, fb_free, busy); else pass++;
    tick; done = 5'b00001;
    tick; done = 0;
    @(negedge clk);
    chk++; if ({cmd_if.valid, cmd_if.data} !== {1'b1, cw(1, 5)})
      $display("FAIL bp_cmd1 got %b/%h exp 1/%h", cmd_if.valid, cmd_if.data, cw(1, 5)); else pass++;
    cmd_if.ready = 1;
    tick; cmd_if.ready = 0; done = 5'b00010;
    tick; done = 0;
    @(negedge clk);
    chk++; if (fb_free !== 8'h20) $display("FAIL bp_free got %h exp 20", fb_free); else pass++;
    tick;
  endtask

  task automatic test_reset_wait;
    int activity = 0;
    settings.enable = 5'b00001; cmd_if.ready = 1;
    sync_if.valid = 1; sync_if.data = 6;
    tick; sync_if.data = 1;
    tick; sync_if.valid = 0;
    tick; @(negedge clk);
    chk++; if ({cmd_if.valid, busy} !== 2'b01) $display("FAIL rw_in_wait got %b/%b exp 0/1", cmd_if.valid, busy); else pass++;
    tick; rstn = 1'b0;
    #1;
    chk++; if ({sync_if.ready, cmd_if.valid, cmd_if.data, fb_free, drop, busy} !== 18'd0)
      $display("FAIL rw_async_clear got %b/%b/%h/%h/%b/%b exp all 0",
               sync_if.ready, cmd_if.valid, cmd_if.data, fb_free, drop, busy); else pass++;
    tick; tick; rstn = 1'b1; done = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmd_if.valid || fb_free != 0 || busy) activity++;
      tick; done = 0;
    end
    chk++; if (activity !== 0) $display("FAIL rw_post_activity got %0d exp 0", activity); else pass++;
    sync_if.valid = 1; sync_if.data = 6;
    @(negedge clk);
    chk++; if ({sync_if.ready, drop} !== 2'b10) $display("FAIL rw_reaccept got %b/%b exp 1/0", sync_if.ready, drop); else pass++;
    tick; sync_if.valid = 0;
    tick; @(negedge clk);
    chk++; if ({cmd_if.valid, cmd_if.data} !== {1'b1, cw(0, 6)})
      $display("FAIL rw_cmd got %b/%h exp 1/%h", cmd_if.valid, cmd_if.data, cw(0, 6)); else pass++;
    tick; cmd_if.ready = 0; done = 1;
    tick; done = 0;
    @(negedge clk);
    chk++; if (fb_free !== 8'h40) $display("FAIL rw_free got %h exp 40", fb_free); else pass++;
    tick;
  endtask

  // Frame-level model: each accepted non-duplicate fnum becomes a frame whose
  // expected commands are its enabled channels in ascending order.
  task automatic test_random(input logic [4:0] mask, input int ncyc);
    logic [7:0] pend = '0;
    int exp_rel[$], exp_cnt[$];
    logic [5:0] exp_cmd[$];
    int done_cnt = 0, done_ch = 0, stray;
    logic [2:0] f;
    settings.enable = mask;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      sync_if.valid = (cyc < ncyc - 150) ? 1'($urandom_range(0, 1)) : 1'b0;
      sync_if.data  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      cmd_if.ready  = ($urandom_range(0, 3) != 0);
      done = 0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) done = 5'(1 << done_ch);
        else if ($urandom_range(0, 2) == 0) begin
          stray = $urandom_range(0, 4);
          if (stray != done_ch) done = 5'(1 << stray);
        end
      end
      @(negedge clk);
      if (fb_free != 0) begin
        chk++;
        if (exp_rel.size() == 0 || fb_free !== 8'(1 << exp_rel[0]) || exp_cnt[0] != 0)
          $display("FAIL rnd_free got %h exp %h", fb_free, exp_rel.size() ? 8'(1 << exp_rel[0]) : 8'h0);
        else pass++;
        if (exp_rel.size() != 0) begin
          pend[exp_rel[0]] = 1'b0;
          void'(exp_rel.pop_front());
          void'(exp_cnt.pop_front());
        end
      end
      if (sync_if.valid && sync_if.ready) begin
        f = sync_if.data;
        chk++; if (drop !== pend[f]) $display("FAIL rnd_drop fnum %0d got %b exp %b", f, drop, pend[f]); else pass++;
        if (!pend[f]) begin
          pend[f] = 1'b1;
          exp_rel.push_back(int'(f));
          exp_cnt.push_back($countones(mask));
          for (int ch = 0; ch < 5; ch++)
            if (mask[ch]) exp_cmd.push_back(cw(ch, int'(f)));
        end
      end else begin
        chk++; if (drop !== 1'b0) $display("FAIL rnd_drop_idle got %b exp 0", drop); else pass++;
      end
      if (cmd_if.valid && cmd_if.ready) begin
        chk++;
        if (exp_cmd.size() == 0 || cmd_if.data !== exp_cmd[0])
          $display("FAIL rnd_cmd got %h exp %h", cmd_if.data, exp_cmd.size() ? exp_cmd[0] : 6'h0);
        else pass++;
        if (exp_cmd.size() != 0) begin
          done_ch = int'(exp_cmd[0][5:3]);
          void'(exp_cmd.pop_front());
          if (exp_cnt.size() != 0) exp_cnt[0]--;
        end
        done_cnt = $urandom_range(1, 3);
      end
      tick;
    end
    done = 0; cmd_if.ready = 0; sync_if.valid = 0;
    @(negedge clk);
    chk++; if (exp_rel.size() != 0 || exp_cmd.size() != 0 || busy !== 1'b0)
      $display("FAIL rnd_drain got frames %0d cmds %0d busy %b exp 0/0/0", exp_rel.size(), exp_cmd.size(), busy);
    else pass++;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sparse;
    test_duplicate;
    test_full;
    test_backpressure;
    test_reset_wait;
    test_random(5'h1F, 700);
    test_random(5'b01010, 600);
    test_random(5'b00000, 400);
    test_random(5'($urandom_range(1, 31)), 600);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/artec_sync_dispatch.md
# artec_sync_dispatch

Consumer at the far end of the header-sync valid/ready channel. It accepts synchronized frame numbers, meaning frames that are complete on every enabled channel, and queues them. For each queued frame it issues one read command per enabled channel and waits for each channel's completion. It then releases the frame buffer slot back to the writer side. It sits between the header-sync stage and the DMA read engines.

## Interface
- CH_NUM, 5, number of AXIS channels
- FB_NUM, 8, frame buffer slots; power of 2, ≥2
- DEPTH, 4, sync queue depth; power of 2, ≥2

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- settings_i  in  artec_dma_pkg::settings_t  per-channel `enable` is used
- sync_i  artec_vr_if.slave  valid/ready, data = fnum [$clog2(FB_NUM)-1:0]
- cmd_o  artec_vr_if.master  valid/ready, data = sync_cmd_t {ch, fnum}
- done_i  in  CH_NUM  per-channel one-cycle read-complete pulse
- fb_free_o  out  FB_NUM  one-hot, one-cycle slot release pulse
- drop_o  out  1  one-cycle pulse when a duplicate fnum is discarded
- busy_o  out  1  FSM not in IDLE, or queue not empty

## Operation
- Accept: a transfer occurs on sync_i.valid && sync_i.ready. sync_i.ready = !full, with no dependence on valid.
- Pending bitmap, FB_NUM bits:
  - An accepted fnum whose pending bit is clear is written to the queue and its pending bit is set.
  - An accepted fnum whose pending bit is already set is dropped; drop_o pulses and the queue is unchanged.
  - If an accept and a RELEASE of the same fnum occur in the same cycle, the fnum is not a duplicate: it is enqueued and its pending bit ends set.
- Queue behaviour:
  - FIFO, DEPTH entries.
  - A push and a pop in the same cycle are legal when the queue is non-empty.
  - When full, ready stays low even in a pop cycle; ready rises the cycle after the pop.
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
  - IDLE: if the queue is non-empty, pop it into cur_fnum and latch en_mask from settings_i. ch_idx = lowest set bit of en_mask. Go to ISSUE, or to RELEASE if en_mask == 0.
  - ISSUE: cmd_o.valid = 1, cmd_o.data = {ch_idx, cur_fnum}, held stable until cmd_o.ready. Go to WAIT on handshake.
  - WAIT: wait for done_i[ch_idx]; pulses on other channels are ignored. On the pulse, go to ISSUE with the next higher set bit of en_mask, or to RELEASE if none remains.
  - RELEASE: fb_free_o[cur_fnum] = 1 for one cycle, clear the pending bit, go to IDLE.
- Changes to settings_i during a frame do not affect the frame in progress, because en_mask is latched.
- A done_i pulse in the same cycle as the cmd_o handshake is ignored. A completion counts only in WAIT.

## Timing
- Reset values:
  - sync_i.ready = 0 while rstn is low; it is 1 from the first cycle after release.
  - cmd_o.valid = 0, cmd_o.data = 0, fb_free_o = 0, drop_o = 0, busy_o = 0.
  - Queue empty, pending bitmap = 0, FSM in IDLE.
- Reset asserted mid-operation: all state clears immediately, with no release pulse for the in-flight frame.
- Latency:
  - Accept in cycle N → pop in N+1 → cmd_o.valid in N+2.
  - done_i in cycle M → next cmd_o.valid in M+1, or fb_free_o in M+1 if it was the last channel.
  - IDLE in M+2; the next pop can occur in M+2.
- Empty mask: pop in N+1, fb_free_o in N+2.
- Queue pointers are $clog2(DEPTH)+1 bits with a wrap bit; full/empty is derived from pointer comparison.

## Structure
- artec_dma_pkg gets:
  - `sync_cmd_t` packed struct: ch [$clog2(CH_NUM)-1:0], fnum [$clog2(FB_NUM)-1:0].
  - `dispatch_state_t` enum.
- Sub-module artec_fnum_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/dout. The remaining logic (FSM, pending bitmap, next-channel priority search) stays in artec_sync_dispatch.

## Test plan
- Basic frame: all 5 channels enabled, sync fnum=3. Expect commands {0,3} through {4,3} in order, each following the previous done_i, then fb_free_o = 8'b0000_1000 for one cycle.
- Sparse mask: enable = 5'b10100, sync fnum=7. Expect only {2,7} and {4,7}. The enable mask is changed to all-ones during WAIT, with no effect; fb_free_o[7] pulses.
- Duplicate fnum: fnum=2 is accepted twice before its release. Expect drop_o on the second accept, a single command sequence, and one fb_free_o[2].
- Full queue: cmd_o.ready held at 0; push fnum 0–4. After the first pop, 4 entries fit and sync_i.ready falls when the 4th entry is written. Release cmd_o.ready; frames are served 0,1,2,3,4 in order.
- Backpressure and stray done:
  - cmd_o.ready is low for 5 cycles; cmd_o.data must stay stable throughout.
  - done_i[1] pulses while waiting on channel 0; it is ignored and no advance occurs.
- Reset during WAIT: assert rstn low with a frame in WAIT. Expect all outputs at reset values, no fb_free_o pulse, and an empty queue afterwards.
